// File: rtl/mux_scan_if.sv
// Bundle between the scan controller and its surroundings: control in, mux y in,
// select lines and the assembled word out.
interface mux_scan_if;
    logic       start_in;
    logic       mode_in;
    logic       y_in;
    logic       b_out;
    logic       c_out;
    logic [3:0] word_out;
    logic       valid_out;
    logic       busy_out;

    // slave: the scan controller
    modport slave (
        input  start_in, mode_in, y_in,
        output b_out, c_out, word_out, valid_out, busy_out
    );

    // master: control logic plus the mux feeding y back
    modport master (
        output start_in, mode_in, y_in,
        input  b_out, c_out, word_out, valid_out, busy_out
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the 4x1 mux selects through channels 0..3, samples y after each dwell and
// publishes the assembled 4-bit word with a one-cycle valid pulse.
module mux_scan_ctrl #(
    parameter int          DWELL = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    mux_scan_if.slave  bus
);

    localparam int             EffDwell = (DWELL < 1) ? 1 : DWELL;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(EffDwell - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [3:0]       word_q, word_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= StIdle;
            sel_q    <= 2'b00;
            cnt_q    <= '0;
            shadow_q <= 4'b0000;
            word_q   <= 4'b0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel_d = 2'b00;
                if (bus.start_in) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (cnt_q == CntLast) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSample: begin
                shadow_d[sel_q] = bus.y_in;
                if (sel_q == 2'd3) begin
                    // Merge the last sample directly so word and valid land together in DONE.
                    word_d  = {bus.y_in, shadow_q[2:0]};
                    valid_d = 1'b1;
                    sel_d   = 2'b00;
                    state_d = StDone;
                end else begin
                    sel_d   = sel_q + 2'd1;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StDone: begin
                sel_d   = 2'b00;
                cnt_d   = '0;
                state_d = bus.mode_in ? StSettle : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.b_out     = sel_q[1];
    assign bus.c_out     = sel_q[0];
    assign bus.word_out  = word_q;
    assign bus.valid_out = valid_q;
    assign bus.busy_out  = (state_q != StIdle);

endmodule
